// File: rtl/fb_pkg.sv
// Shared constants, state encoding and frame buffer geometry for the write arbiter.
package fb_pkg;
    localparam int ADDR_W          = 19;
    localparam int DATA_W          = 5;
    localparam int PIXELS          = 76800;
    localparam int TRANSPARENT_IDX = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2
    } fb_state_t;
endpackage

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Round-robin grant among N requesters; the search starts one past the last winner.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] ptr
);
    int   win;
    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        win   = 0;
        idx   = 0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = idx;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= PTR_W'((win + 1) % N);
        end
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// Frame buffer write sequencer: per-frame clear, then round-robin client writes.
// Build option: FB_TRANSPARENT_SKIP_EN drops client writes of the transparent index.
//
// state | meaning
// IDLE  | after reset, waiting for the first frame_start
// CLEAR | one background write per cycle over the whole buffer
// DRAW  | clients share the write port round-robin
module fb_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PIXELS  = fb_pkg::PIXELS,
    parameter int ADDR_W  = fb_pkg::ADDR_W,
    parameter int DATA_W  = fb_pkg::DATA_W
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_start,
    input  logic [DATA_W-1:0]         clear_color,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_data,
    output logic                      busy,
    output logic                      clear_done,
    output logic                      addr_err
);
    import fb_pkg::*;

    localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    fb_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [DATA_W-1:0]   color_q;
    logic [NUM_REQ-1:0]  gnt;
    logic [PTR_W-1:0]    rr_ptr_unused;
    logic                transfer;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                out_of_range;
    logic                skip;

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .Clk     (Clk),
        .Reset   (Reset),
        .req     (req_valid),
        .advance (transfer),
        .gnt     (gnt),
        .ptr     (rr_ptr_unused)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = CLEAR;
            CLEAR:   if (!frame_start && cnt_q == LAST_ADDR) state_d = DRAW;
            DRAW:    if (frame_start) state_d = CLEAR;
            default: state_d = IDLE;
        endcase
    end

    // frame_start wins over a pending grant so the clear begins cleanly.
    always_comb begin
        req_ready = '0;
        if (state_q == DRAW && !frame_start) req_ready = gnt & req_valid;
        transfer = |req_ready;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        out_of_range = sel_addr > LAST_ADDR;
`ifdef FB_TRANSPARENT_SKIP_EN
        skip = (sel_data == DATA_W'(TRANSPARENT_IDX));
`else
        skip = 1'b0;
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q      <= '0;
            color_q    <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            clear_done <= 1'b0;
            busy       <= (state_q == CLEAR);
            if (frame_start) begin
                cnt_q   <= '0;
                color_q <= clear_color;
            end else if (state_q == CLEAR) begin
                ram_we     <= 1'b1;
                ram_addr   <= cnt_q;
                ram_data   <= color_q;
                clear_done <= (cnt_q == LAST_ADDR);
                cnt_q      <= cnt_q + ADDR_W'(1);
            end else if (transfer) begin
                if (out_of_range) begin
                    addr_err <= 1'b1;
                end else if (!skip) begin
                    ram_we   <= 1'b1;
                    ram_addr <= sel_addr;
                    ram_data <= sel_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized bench for fb_write_arbiter against a behavioural frame-write model.
module tb_fb_write_arbiter;
    localparam int N   = 2;
    localparam int PIX = 16;
    localparam int AW  = 19;
    localparam int DW  = 5;
`ifdef FB_TRANSPARENT_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Reset;
    logic              frame_start;
    logic [DW-1:0]     clear_color;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_data;
    logic              busy;
    logic              clear_done;
    logic              addr_err;

    always #5 Clk = ~Clk;

    fb_write_arbiter #(.NUM_REQ(N), .PIXELS(PIX), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .clear_color (clear_color),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .busy        (busy),
        .clear_done  (clear_done),
        .addr_err    (addr_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 clearing, 2 drawing; m_next is where the next search begins.
    int m_mode, m_pos, m_color, m_next, m_err;
    int e_we, e_addr, e_data, e_busy, e_done;
    int last_winner;
    int done_seen, busy_seen, writes_seen;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_color = 0; m_next = 0; m_err = 0;
        e_we = 0; e_addr = 0; e_data = 0; e_busy = 0; e_done = 0;
        last_winner = -1;
    endtask

    function automatic int c_addr(int i);
        return int'(req_addr[i*AW +: AW]);
    endfunction

    function automatic int c_data(int i);
        return int'(req_data[i*DW +: DW]);
    endfunction

    task automatic cycle();
        int win, c, a, d, exp_rdy;
        @(negedge Clk);
        win = -1;
        if (m_mode == 2 && !frame_start) begin
            for (int k = 0; k < N; k++) begin
                c = (m_next + k) % N;
                if (win < 0 && req_valid[c]) win = c;
            end
        end
        exp_rdy = (win < 0) ? 0 : (1 << win);
        check_eq("req_ready", 32'(req_ready), exp_rdy);
        last_winner = win;
        e_we = 0; e_done = 0; e_busy = (m_mode == 1) ? 1 : 0;
        if (frame_start) begin
            m_mode = 1; m_pos = 0; m_color = int'(clear_color);
        end else if (m_mode == 1) begin
            e_we = 1; e_addr = m_pos; e_data = m_color;
            e_done = (m_pos == PIX - 1) ? 1 : 0;
            m_pos++;
            if (m_pos == PIX) m_mode = 2;
        end else if (win >= 0) begin
            a = c_addr(win); d = c_data(win);
            m_next = (win + 1) % N;
            if (a >= PIX) m_err = 1;
            else if (!(SKIP && d == 0)) begin
                e_we = 1; e_addr = a; e_data = d;
            end
        end
        @(posedge Clk); #1;
        check_eq("ram_we", 32'(ram_we), e_we);
        if (e_we != 0) begin
            check_eq("ram_addr", 32'(ram_addr), e_addr);
            check_eq("ram_data", 32'(ram_data), e_data);
        end
        check_eq("busy", 32'(busy), e_busy);
        check_eq("clear_done", 32'(clear_done), e_done);
        check_eq("addr_err", 32'(addr_err), m_err);
        if (clear_done) done_seen++;
        if (busy)       busy_seen++;
        if (ram_we)     writes_seen++;
    endtask

    // A client changes its request only once the previous one was taken (or it was idle).
    task automatic randomize_clients();
        for (int c = 0; c < N; c++) begin
            if (!req_valid[c] || last_winner == c) begin
                req_valid[c] = ($urandom_range(0, 3) != 0);
                req_addr[c*AW +: AW] = AW'($urandom_range(0, PIX + 3));
                req_data[c*DW +: DW] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(0, 31));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; frame_start = 1'b0; clear_color = '0;
        req_valid = '0; req_addr = '0; req_data = '0;
        model_reset();
        done_seen = 0; busy_seen = 0; writes_seen = 0;
        #12;
        check_eq("reset_outputs", 32'({ram_we, ram_addr, ram_data, busy, clear_done, addr_err, req_ready}), 0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        req_valid = '1;
        repeat (20) cycle();
        check_eq("idle_quiet", 32'({ram_we, ram_addr, ram_data, busy, clear_done, addr_err}), 0);

        clear_color = 5'h1A; frame_start = 1'b1;
        cycle();
        frame_start = 1'b0; clear_color = '0;
        done_seen = 0; busy_seen = 0; writes_seen = 0;
        repeat (PIX) cycle();
        check_eq("clear_done_count", done_seen, 1);
        check_eq("busy_cycles", busy_seen, PIX);
        check_eq("clear_writes", writes_seen, PIX);

        req_valid = 2'b11;
        req_addr[0 +: AW] = AW'(3);  req_data[0 +: DW] = 5'h07;
        req_addr[AW +: AW] = AW'(9); req_data[DW +: DW] = 5'h0C;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_eq("rr_order", last_winner, i % 2);
        end

        req_addr[AW +: AW] = AW'(PIX);
        repeat (4) cycle();
        check_eq("addr_err_set", 32'(addr_err), 1);

        for (int i = 0; i < 300; i++) begin
            frame_start = ($urandom_range(0, 49) == 0);
            clear_color = DW'($urandom_range(0, 31));
            cycle();
            randomize_clients();
        end
        frame_start = 1'b0;

        req_valid = '0;
        clear_color = 5'h05; frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        for (int k = 0; k < 20 && m_pos != 7; k++) cycle();
        check_eq("restart_point", m_pos, 7);
        clear_color = 5'h03; frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        done_seen = 0; writes_seen = 0;
        repeat (PIX + 1) cycle();
        check_eq("restart_done_count", done_seen, 1);
        check_eq("restart_writes", writes_seen, PIX);

        req_valid = 2'b01;
        req_addr[0 +: AW] = AW'(5); req_data[0 +: DW] = '0;
        cycle();
        req_valid = 2'b11;
        req_addr[AW +: AW] = AW'(6); req_data[DW +: DW] = 5'h11;
        repeat (3) cycle();

        #2 Reset = 1'b1;
        #1;
        check_eq("async_reset", 32'({ram_we, ram_addr, ram_data, busy, clear_done, addr_err, req_ready}), 0);
        model_reset();
        @(posedge Clk); #1;
        Reset = 1'b0;
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Sequences all writes into the 320x240 palette-index frame buffer RAM (5-bit index, 19-bit address, single write port).
- At each frame start it runs a full-buffer clear to a background index.
- After the clear, it shares the write port round-robin between NUM_REQ pixel-writer clients (sprite and text engines) using a valid/ready handshake.
- It sits between the draw engines and the frame buffer write port. The VGA read side is untouched.

Parameters:
- NUM_REQ, 2, number of pixel-write requesters (1..4)
- PIXELS, 76800, number of frame buffer entries cleared and valid addresses are 0..PIXELS-1 (bench uses 16)
- ADDR_W, 19, address width
- DATA_W, 5, palette index width

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- frame_start  in  1  single-cycle pulse (vsync-derived) that starts a clear
- clear_color  in  DATA_W  background index, sampled on frame_start
- req_valid  in  NUM_REQ  per-client write request
- req_addr  in  NUM_REQ*ADDR_W  packed client addresses; client i is at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed client palette indices
- req_ready  out  NUM_REQ  per-client accept, one-hot or zero
- ram_we  out  1  frame buffer write enable
- ram_addr  out  ADDR_W  frame buffer write address
- ram_data  out  DATA_W  frame buffer write data
- busy  out  1  high while in CLEAR
- clear_done  out  1  one-cycle pulse when the last clear write is presented
- addr_err  out  1  sticky; set on an accepted out-of-range request

Behaviour:
- States: IDLE, CLEAR, DRAW.
- Reset (asynchronous) forces:
  - state = IDLE
  - all outputs 0
  - clear counter = 0
  - round-robin pointer = 0
- IDLE:
  - No service; req_ready = 0.
  - frame_start -> CLEAR, latch clear_color, counter = 0.
- CLEAR:
  - One write per cycle; counter runs 0..PIXELS-1.
  - Outputs are registered: the cycle after entering CLEAR, ram_we = 1, ram_addr = 0, ram_data = latched color.
  - Each following cycle increments ram_addr.
  - clear_done = 1 in the same cycle ram_addr = PIXELS-1 is presented.
  - The next state after the last write is DRAW.
  - req_ready = 0 throughout.
  - busy = 1 throughout CLEAR.
- frame_start during CLEAR: restart. Counter = 0, re-latch clear_color. No clear_done for the aborted pass.
- DRAW, handshake:
  - req_ready is combinational: high only for the granted client, and only when that client's req_valid = 1.
  - A transfer occurs when valid and ready are both high.
  - Clients hold valid, addr and data stable until the transfer.
- DRAW, round-robin arbitration:
  - The search starts at the client after the last granted one.
  - After reset the search starts at client 0.
  - One transfer per cycle maximum.
  - The pointer advances only on a transfer.
- DRAW, write timing:
  - Accepted data appears on ram_we/ram_addr/ram_data exactly 1 cycle after the transfer.
  - ram_we = 0 in cycles with no transfer.
- Out-of-range addresses (req_addr >= PIXELS): the request is accepted (ready high), no write is issued (ram_we = 0), and addr_err is set. addr_err clears only on Reset.
- frame_start during DRAW:
  - -> CLEAR in the next cycle. req_ready = 0 in the frame_start cycle.
  - A transfer completed in the prior cycle still issues its registered write before the first clear write.
- DRAW persists until frame_start.
- Address arithmetic: the counter is ADDR_W bits with no wrap. Termination compares against PIXELS-1.

Optional Feature:
- Macro FB_TRANSPARENT_SKIP_EN.
- Defined:
  - A request with req_data == 0 (transparent palette index) is accepted normally, advances the pointer, and issues no write (ram_we = 0).
  - Clear writes are unaffected.
- Undefined: index 0 is written like any other value.

Decomposition:
- Package fb_pkg holds:
  - ADDR_W = 19, DATA_W = 5, PIXELS = 76800
  - TRANSPARENT_IDX = 0
  - typedef enum logic [1:0] {IDLE, CLEAR, DRAW} fb_state_t
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], advance, Clk, Reset.
  - Outputs: one-hot gnt[N], held pointer register.
- The top module contains the FSM, clear counter, output registers and range check.

Test Plan:
- Reset, then no frame_start, with req_valid = 2'b11 -> req_ready = 0, ram_we = 0, all outputs 0 for 20 cycles.
- PIXELS = 16, frame_start with clear_color = 5'h1A -> 16 consecutive writes at addr 0..15 with data 1A; clear_done coincides with addr 15; busy high for exactly those 16 cycles; state becomes DRAW.
- DRAW, both clients valid continuously (client 0 addr 3 data 07, client 1 addr 9 data 0C) -> grants alternate 0,1,0,1; each write appears 1 cycle after its transfer.
- DRAW, client 1 req_addr = 16 with PIXELS = 16 -> accepted, no ram_we, addr_err = 1 and stays 1 until Reset.
- frame_start on clear count 7 -> counter restarts at addr 0 with the new color; one clear_done after 16 further writes. Asynchronous Reset mid-DRAW -> outputs 0 immediately, state IDLE.
- With FB_TRANSPARENT_SKIP_EN, client 0 data 0 -> accepted, ram_we = 0, pointer advances. Without the macro -> write with data 0 is issued.
